// File: rtl/maindec_ext_if.sv
// Control bundle between the multicycle main decoder and the datapath.
// The decoder is the master: it drives every enable, select and status
// signal. The datapath/memory side is the slave: it supplies the opcode
// and the memory ready strobe.
interface maindec_ext_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             memready;
    logic             memreq;
    logic             pcwrite;
    logic             memwrite;
    logic             irwrite;
    logic             regwrite;
    logic             alusrca;
    logic             iord;
    logic             branch;
    logic             bne;
    logic [1:0]       regdst;
    logic [1:0]       wdsel;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic [2:0]       aluop;
    logic             err;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, memready,
        output memreq, pcwrite, memwrite, irwrite, regwrite, alusrca, iord,
               branch, bne, regdst, wdsel, alusrcb, pcsrc, aluop, err,
               instr_done, instr_count
    );

    modport slave (
        output opcode, memready,
        input  memreq, pcwrite, memwrite, irwrite, regwrite, alusrca, iord,
               branch, bne, regdst, wdsel, alusrcb, pcsrc, aluop, err,
               instr_done, instr_count
    );
endinterface

// File: rtl/maindec_ext.sv
// Multicycle MIPS main controller with ANDI/ORI/BNE/JAL, a memready
// handshake on every memory access, configurable error recovery and a
// retired-instruction counter. Moore outputs come straight from the state;
// only the memory-completion strobes are gated by memready.
module maindec_ext #(
    parameter bit EXT_EN      = 1'b1,
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit ERR_STICKY  = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    maindec_ext_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [4:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
        BEQEX, BNEEX, ADDIEX, ANDIEX, ORIEX, IMMWB, JEX, JALEX, ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rdy;
    logic             done;

    // Memory completion: when waiting is disabled every access finishes at once
    assign rdy = MEM_WAIT_EN ? bus.memready : 1'b1;

    // Output decode, next-state selection and retire counting
    always_comb begin
        bus.memreq   = 1'b0;
        bus.pcwrite  = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.iord     = 1'b0;
        bus.branch   = 1'b0;
        bus.bne      = 1'b0;
        bus.regdst   = 2'b00;
        bus.wdsel    = 2'b00;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        bus.aluop    = 3'b000;
        bus.err      = 1'b0;
        done         = 1'b0;
        state_d      = state_q;

        case (state_q)
            FETCH: begin
                bus.memreq  = 1'b1;
                bus.alusrcb = 2'b01;
                bus.irwrite = rdy;
                bus.pcwrite = rdy;
                if (rdy) state_d = DECODE;
            end
            DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    OP_BNE:       state_d = EXT_EN ? BNEEX  : ERROR;
                    OP_ANDI:      state_d = EXT_EN ? ANDIEX : ERROR;
                    OP_ORI:       state_d = EXT_EN ? ORIEX  : ERROR;
                    OP_JAL:       state_d = EXT_EN ? JALEX  : ERROR;
                    default:      state_d = ERROR;
                endcase
            end
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                if (bus.opcode == OP_LW)      state_d = MEMRD;
                else if (bus.opcode == OP_SW) state_d = MEMWR;
                else                          state_d = ERROR;
            end
            MEMRD: begin
                bus.memreq = 1'b1;
                bus.iord   = 1'b1;
                if (rdy) state_d = MEMWB;
            end
            MEMWB: begin
                bus.regwrite = 1'b1;
                bus.wdsel    = 2'b01;
                done         = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                // Request stays steady while stalled; the store commits on rdy
                bus.memreq   = 1'b1;
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                done         = rdy;
                if (rdy) state_d = FETCH;
            end
            RTYPEEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 3'b010;
                state_d     = RTYPEWB;
            end
            RTYPEWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 2'b01;
                done         = 1'b1;
                state_d      = FETCH;
            end
            BEQEX, BNEEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 3'b001;
                bus.pcsrc   = 2'b01;
                bus.branch  = 1'b1;
                bus.bne     = (state_q == BNEEX);
                done        = 1'b1;
                state_d     = FETCH;
            end
            ADDIEX, ANDIEX, ORIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                bus.aluop   = (state_q == ANDIEX) ? 3'b011 :
                              (state_q == ORIEX)  ? 3'b100 : 3'b000;
                state_d     = IMMWB;
            end
            IMMWB: begin
                bus.regwrite = 1'b1;
                done         = 1'b1;
                state_d      = FETCH;
            end
            JEX: begin
                bus.pcsrc   = 2'b10;
                bus.pcwrite = 1'b1;
                done        = 1'b1;
                state_d     = FETCH;
            end
            JALEX: begin
                // PC already holds PC+4, so it is the return address for $31
                bus.pcsrc    = 2'b10;
                bus.pcwrite  = 1'b1;
                bus.regwrite = 1'b1;
                bus.regdst   = 2'b10;
                bus.wdsel    = 2'b10;
                done         = 1'b1;
                state_d      = FETCH;
            end
            ERROR: begin
                bus.err = 1'b1;
                state_d = ERR_STICKY ? ERROR : FETCH;
            end
            default: state_d = ERROR;
        endcase

        count_d = done ? count_q + CNT_W'(1) : count_q;
    end

    assign bus.instr_done  = done;
    assign bus.instr_count = count_q;

    // State and counter registers; reset wins at any point in an instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_maindec_ext.sv
// Self-checking bench for maindec_ext. Two instances: A with all features
// on (32-bit counter), B with extensions off, no memory waits, one-cycle
// error and a 4-bit counter. Expected control words come from a per-
// instruction planner built from the controller's documented step list.
module tb_maindec_ext;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BAD   = 6'b111111;
    localparam int CNT_B = 4;

    typedef struct packed {
        logic       memreq, pcwrite, memwrite, irwrite, regwrite;
        logic       alusrca, iord, branch, bne;
        logic [1:0] regdst, wdsel, alusrcb, pcsrc;
        logic [2:0] aluop;
        logic       err, instr_done;
    } ctl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, reset_b;
    maindec_ext_if #(.CNT_W(32))    bus_a ();
    maindec_ext_if #(.CNT_W(CNT_B)) bus_b ();

    maindec_ext #(.EXT_EN(1'b1), .MEM_WAIT_EN(1'b1), .ERR_STICKY(1'b1), .CNT_W(32))
        dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
    maindec_ext #(.EXT_EN(1'b0), .MEM_WAIT_EN(1'b0), .ERR_STICKY(1'b0), .CNT_W(CNT_B))
        dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

    ctl_t obs_a, obs_b;
    assign obs_a = {bus_a.memreq, bus_a.pcwrite, bus_a.memwrite, bus_a.irwrite, bus_a.regwrite,
                    bus_a.alusrca, bus_a.iord, bus_a.branch, bus_a.bne, bus_a.regdst, bus_a.wdsel,
                    bus_a.alusrcb, bus_a.pcsrc, bus_a.aluop, bus_a.err, bus_a.instr_done};
    assign obs_b = {bus_b.memreq, bus_b.pcwrite, bus_b.memwrite, bus_b.irwrite, bus_b.regwrite,
                    bus_b.alusrca, bus_b.iord, bus_b.branch, bus_b.bne, bus_b.regdst, bus_b.wdsel,
                    bus_b.alusrcb, bus_b.pcsrc, bus_b.aluop, bus_b.err, bus_b.instr_done};

    int total = 0;
    int bad   = 0;
    logic [31:0]      exp_cnt_a;
    logic [CNT_B-1:0] exp_cnt_b;

    ctl_t       exp_q[$];
    ctl_t       obs_q[$];
    bit         rdy_q[$];
    logic [5:0] op_q[$];

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void clear_plan();
        exp_q.delete(); rdy_q.delete(); op_q.delete();
    endfunction

    function automatic void push(input ctl_t c, input bit r, input logic [5:0] op);
        exp_q.push_back(c); rdy_q.push_back(r); op_q.push_back(op);
    endfunction

    function automatic ctl_t fetch_word(input bit ready);
        ctl_t c = '0;
        c.memreq = 1'b1; c.alusrcb = 2'b01; c.irwrite = ready; c.pcwrite = ready;
        return c;
    endfunction

    // A memory access of wt stall cycles; without waiting it always takes one
    // cycle and memready is deliberately driven low to show it is ignored.
    // mode 1: fetch strobes on completion, mode 2: retire on completion.
    function automatic void push_access(input ctl_t base, input bit mw, input int wt,
                                        input logic [5:0] op, input int mode);
        int cycles = mw ? wt + 1 : 1;
        for (int i = 0; i < cycles; i++) begin
            ctl_t c = base;
            bit   done_now = (i == cycles - 1);
            bit   r = mw ? done_now : ((wt > 0) ? 1'b0 : rb());
            if (mode == 1) begin c.irwrite = done_now; c.pcwrite = done_now; end
            if (mode == 2) c.instr_done = done_now;
            push(c, r, op);
        end
    endfunction

    // Appends the cycle-by-cycle control words of one instruction starting in
    // FETCH; returns the number of retirements it produces.
    function automatic int plan(input logic [5:0] op, input bit ext, input bit mw,
                                input int fwait, input int mwait);
        ctl_t c;
        logic [5:0] eff;
        bit is_ext = (op == OP_BNE) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_JAL);
        eff = (is_ext && !ext) ? OP_BAD : op;
        c = '0; c.memreq = 1'b1; c.alusrcb = 2'b01;
        push_access(c, mw, fwait, op, 1);
        c = '0; c.alusrcb = 2'b11;
        push(c, rb(), op);
        case (eff)
            OP_LW, OP_SW: begin
                c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10;
                push(c, rb(), op);
                c = '0; c.memreq = 1'b1; c.iord = 1'b1;
                if (eff == OP_LW) begin
                    push_access(c, mw, mwait, op, 0);
                    c = '0; c.regwrite = 1'b1; c.wdsel = 2'b01; c.instr_done = 1'b1;
                    push(c, rb(), op);
                end else begin
                    c.memwrite = 1'b1;
                    push_access(c, mw, mwait, op, 2);
                end
                return 1;
            end
            OP_RTYPE: begin
                c = '0; c.alusrca = 1'b1; c.aluop = 3'b010; push(c, rb(), op);
                c = '0; c.regwrite = 1'b1; c.regdst = 2'b01; c.instr_done = 1'b1;
                push(c, rb(), op);
                return 1;
            end
            OP_BEQ, OP_BNE: begin
                c = '0; c.alusrca = 1'b1; c.aluop = 3'b001; c.pcsrc = 2'b01;
                c.branch = 1'b1; c.bne = (eff == OP_BNE); c.instr_done = 1'b1;
                push(c, rb(), op);
                return 1;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10;
                c.aluop = (eff == OP_ANDI) ? 3'b011 : (eff == OP_ORI) ? 3'b100 : 3'b000;
                push(c, rb(), op);
                c = '0; c.regwrite = 1'b1; c.instr_done = 1'b1;
                push(c, rb(), op);
                return 1;
            end
            OP_J, OP_JAL: begin
                c = '0; c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.instr_done = 1'b1;
                if (eff == OP_JAL) begin
                    c.regwrite = 1'b1; c.regdst = 2'b10; c.wdsel = 2'b10;
                end
                push(c, rb(), op);
                return 1;
            end
            default: begin
                c = '0; c.err = 1'b1; push(c, rb(), op);
                return 0;
            end
        endcase
    endfunction

    // Drives the planned inputs one cycle at a time and records the outputs
    task automatic exec_plan(input bit which, input int n);
        int lim = (n < 0 || n > exp_q.size()) ? exp_q.size() : n;
        obs_q.delete();
        for (int i = 0; i < lim; i++) begin
            if (which) begin bus_b.opcode = op_q[i]; bus_b.memready = rdy_q[i]; end
            else       begin bus_a.opcode = op_q[i]; bus_a.memready = rdy_q[i]; end
            #1;
            obs_q.push_back(which ? obs_b : obs_a);
            @(negedge clk);
        end
        if (!which) bus_a.memready = 1'b0;
    endtask

    task automatic b_begin();
        reset_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        exp_cnt_b = '0;
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1;
        bus_a.opcode = OP_RTYPE; bus_a.memready = 1'b0;
        bus_b.opcode = OP_RTYPE; bus_b.memready = 1'b0;
        exp_cnt_a = '0; exp_cnt_b = '0;
        @(negedge clk); @(negedge clk);
        reset_a = 1'b0;
        #1;
        total++;
        if (obs_a !== fetch_word(1'b0)) begin
            bad++; $display("FAIL reset_a_stall got=%h exp=%h", obs_a, fetch_word(1'b0));
        end
        total++;
        if (obs_b !== fetch_word(1'b1)) begin
            bad++; $display("FAIL reset_b_nowait got=%h exp=%h", obs_b, fetch_word(1'b1));
        end
        bus_a.memready = 1'b1;
        #1;
        total++;
        if (obs_a !== fetch_word(1'b1)) begin
            bad++; $display("FAIL reset_a_ready got=%h exp=%h", obs_a, fetch_word(1'b1));
        end
        total++;
        if (bus_a.instr_count !== exp_cnt_a || bus_b.instr_count !== exp_cnt_b) begin
            bad++; $display("FAIL reset_count got=%0d/%0d exp=0/0", bus_a.instr_count, bus_b.instr_count);
        end
        bus_a.memready = 1'b0;
        @(negedge clk);
        $display("txn reset checked");
    endtask

    task automatic test_lw();
        clear_plan();
        exp_cnt_a += 32'(plan(OP_LW, 1'b1, 1'b1, 0, 0));
        exec_plan(1'b0, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL lw cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (bus_a.instr_count !== exp_cnt_a) begin
            bad++; $display("FAIL lw_count got=%0d exp=%0d", bus_a.instr_count, exp_cnt_a);
        end
        $display("txn lw cycles=%0d count=%0d", obs_q.size(), bus_a.instr_count);
    endtask

    task automatic test_sw_wait();
        clear_plan();
        exp_cnt_a += 32'(plan(OP_SW, 1'b1, 1'b1, 0, 3));
        exec_plan(1'b0, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL sw_wait cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (bus_a.instr_count !== exp_cnt_a) begin
            bad++; $display("FAIL sw_count got=%0d exp=%0d", bus_a.instr_count, exp_cnt_a);
        end
        $display("txn sw_wait cycles=%0d count=%0d", obs_q.size(), bus_a.instr_count);
    endtask

    task automatic test_fetch_wait();
        clear_plan();
        exp_cnt_a += 32'(plan(OP_RTYPE, 1'b1, 1'b1, 2, 0));
        exec_plan(1'b0, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL fetch_wait_a cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        $display("txn fetch_wait_a cycles=%0d", obs_q.size());
        b_begin();
        clear_plan();
        exp_cnt_b += CNT_B'(plan(OP_RTYPE, 1'b0, 1'b0, 2, 0));
        exec_plan(1'b1, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL fetch_nowait_b cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (bus_b.instr_count !== exp_cnt_b) begin
            bad++; $display("FAIL fetch_b_count got=%0d exp=%0d", bus_b.instr_count, exp_cnt_b);
        end
        reset_b = 1'b1;
        $display("txn fetch_nowait_b cycles=%0d", obs_q.size());
    endtask

    task automatic test_ext_ops();
        logic [5:0] ops [7] = '{OP_JAL, OP_BNE, OP_ANDI, OP_ORI, OP_BEQ, OP_ADDI, OP_J};
        clear_plan();
        foreach (ops[k]) exp_cnt_a += 32'(plan(ops[k], 1'b1, 1'b1, 0, 0));
        exec_plan(1'b0, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL ext_ops cyc=%0d op=%b got=%h exp=%h", i, op_q[i], obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (bus_a.instr_count !== exp_cnt_a) begin
            bad++; $display("FAIL ext_count got=%0d exp=%0d", bus_a.instr_count, exp_cnt_a);
        end
        $display("txn ext_ops_a cycles=%0d count=%0d", obs_q.size(), bus_a.instr_count);
        b_begin();
        clear_plan();
        exp_cnt_b += CNT_B'(plan(OP_JAL, 1'b0, 1'b0, 0, 0));
        exp_cnt_b += CNT_B'(plan(OP_J, 1'b0, 1'b0, 0, 0));
        exec_plan(1'b1, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL jal_noext_b cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (bus_b.instr_count !== exp_cnt_b) begin
            bad++; $display("FAIL jal_noext_count got=%0d exp=%0d", bus_b.instr_count, exp_cnt_b);
        end
        reset_b = 1'b1;
        $display("txn jal_noext_b cycles=%0d", obs_q.size());
    endtask

    task automatic test_random();
        logic [5:0] legal [10] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI,
                                    OP_J, OP_BNE, OP_ANDI, OP_ORI, OP_JAL};
        clear_plan();
        for (int k = 0; k < 40; k++) begin
            logic [5:0] op = legal[$urandom_range(0, 9)];
            int fw = $urandom_range(0, 3);
            int mwt = $urandom_range(0, 3);
            exp_cnt_a += 32'(plan(op, 1'b1, 1'b1, fw, mwt));
            $display("txn rand_a k=%0d op=%b fwait=%0d mwait=%0d", k, op, fw, mwt);
        end
        exec_plan(1'b0, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rand_a cyc=%0d op=%b got=%h exp=%h", i, op_q[i], obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (bus_a.instr_count !== exp_cnt_a) begin
            bad++; $display("FAIL rand_a_count got=%0d exp=%0d", bus_a.instr_count, exp_cnt_a);
        end
        b_begin();
        clear_plan();
        for (int k = 0; k < 30; k++) begin
            logic [5:0] op = (k % 3 == 0) ? 6'($urandom_range(0, 63)) : legal[$urandom_range(0, 9)];
            exp_cnt_b += CNT_B'(plan(op, 1'b0, 1'b0, $urandom_range(0, 2), $urandom_range(0, 2)));
            $display("txn rand_b k=%0d op=%b", k, op);
        end
        exec_plan(1'b1, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rand_b cyc=%0d op=%b got=%h exp=%h", i, op_q[i], obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (bus_b.instr_count !== exp_cnt_b) begin
            bad++; $display("FAIL rand_b_count got=%0d exp=%0d", bus_b.instr_count, exp_cnt_b);
        end
        reset_b = 1'b1;
    endtask

    task automatic test_reset_mid();
        clear_plan();
        void'(plan(OP_RTYPE, 1'b1, 1'b1, 0, 0));
        exec_plan(1'b0, 2);
        bus_a.opcode = OP_RTYPE;
        #1;
        total++;
        if (obs_a !== exp_q[2]) begin
            bad++; $display("FAIL mid_rtypeex got=%h exp=%h", obs_a, exp_q[2]);
        end
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        exp_cnt_a = '0;
        #1;
        total++;
        if (obs_a !== fetch_word(1'b0)) begin
            bad++; $display("FAIL mid_reset_state got=%h exp=%h", obs_a, fetch_word(1'b0));
        end
        total++;
        if (bus_a.instr_count !== exp_cnt_a) begin
            bad++; $display("FAIL mid_reset_count got=%0d exp=%0d", bus_a.instr_count, exp_cnt_a);
        end
        @(negedge clk);
        $display("txn reset_mid count=%0d", bus_a.instr_count);
    endtask

    task automatic test_error_sticky();
        ctl_t e = '0;
        e.err = 1'b1;
        clear_plan();
        exp_cnt_a += 32'(plan(OP_RTYPE, 1'b1, 1'b1, 0, 0));
        exp_cnt_a += 32'(plan(OP_BAD, 1'b1, 1'b1, 0, 0));
        for (int k = 0; k < 9; k++) push(e, rb(), OP_BAD);
        exec_plan(1'b0, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL err_sticky cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (bus_a.instr_count !== exp_cnt_a) begin
            bad++; $display("FAIL err_count got=%0d exp=%0d", bus_a.instr_count, exp_cnt_a);
        end
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        exp_cnt_a = '0;
        #1;
        total++;
        if (obs_a !== fetch_word(1'b0) || bus_a.instr_count !== exp_cnt_a) begin
            bad++; $display("FAIL err_reset got=%h cnt=%0d exp=%h cnt=0", obs_a, bus_a.instr_count, fetch_word(1'b0));
        end
        @(negedge clk);
        $display("txn err_sticky cycles=%0d", obs_q.size());
    endtask

    task automatic test_wrap();
        b_begin();
        clear_plan();
        for (int k = 0; k < 15; k++) exp_cnt_b += CNT_B'(plan(OP_J, 1'b0, 1'b0, 0, 0));
        exec_plan(1'b1, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL wrap_seq cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (bus_b.instr_count !== exp_cnt_b) begin
            bad++; $display("FAIL wrap_15 got=%0d exp=%0d", bus_b.instr_count, exp_cnt_b);
        end
        clear_plan();
        exp_cnt_b += CNT_B'(plan(OP_J, 1'b0, 1'b0, 0, 0));
        exec_plan(1'b1, -1);
        total++;
        if (bus_b.instr_count !== exp_cnt_b) begin
            bad++; $display("FAIL wrap_16 got=%0d exp=%0d", bus_b.instr_count, exp_cnt_b);
        end
        reset_b = 1'b1;
        $display("txn wrap count=%0d", bus_b.instr_count);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_fetch_wait();
        test_ext_ops();
        test_random();
        test_reset_mid();
        test_error_sticky();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
